// File: rtl/asi_pkg.sv
// Shared constants and types for the AXI4 slave write path.
package asi_pkg;

  localparam logic [1:0] BT_FIXED = 2'b00;
  localparam logic [1:0] BT_INCR  = 2'b01;
  localparam logic [1:0] BT_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {WS_IDLE, WS_BURST, WS_BRESP} ws_state_t;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/asi_sfifo.sv
// Synchronous show-ahead FIFO; head entry is visible on dout while not empty.
module asi_sfifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);
  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  // Storage carries no reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[PW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

endmodule

// File: rtl/asi_wr_sync.sv
// Single-clock AXI4 slave write path: buffers AW/W/B, generates beat addresses,
// hands beats to user logic and folds protocol/user errors into BRESP.
//
//  state    | meaning
//  WS_IDLE  | no burst open; pops next AW entry when one is queued
//  WS_BURST | beats of the current burst flow to m_* as W data arrives
//  WS_BRESP | burst finished but B FIFO full; waiting to push the response
module asi_wr_sync
  import asi_pkg::*;
#(
  parameter int DW = 64,
  parameter int AW = 32,
  parameter int IW = 4,
  parameter int OD = 4,
  parameter int WD = 8,
  parameter int BD = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IW-1:0]   AWID,
  input  logic [AW-1:0]   AWADDR,
  input  logic [7:0]      AWLEN,
  input  logic [2:0]      AWSIZE,
  input  logic [1:0]      AWBURST,
  input  logic            AWVALID,
  output logic            AWREADY,
  input  logic [DW-1:0]   WDATA,
  input  logic [DW/8-1:0] WSTRB,
  input  logic            WLAST,
  input  logic            WVALID,
  output logic            WREADY,
  output logic [IW-1:0]   BID,
  output logic [1:0]      BRESP,
  output logic            BVALID,
  input  logic            BREADY,
  output logic [IW-1:0]   m_wid,
  output logic [AW-1:0]   m_waddr,
  output logic [7:0]      m_wlen,
  output logic [2:0]      m_wsize,
  output logic [1:0]      m_wburst,
  output logic [DW-1:0]   m_wdata,
  output logic [DW/8-1:0] m_wstrb,
  output logic            m_wlast,
  output logic            m_wvalid,
  input  logic            m_wready,
  input  logic            m_werr
);
  localparam int         SW     = DW/8;
  localparam logic [2:0] SZ_MAX = 3'($clog2(SW));
  localparam int         AFW    = IW + AW + 13;
  localparam int         WFW    = DW + SW + 1;
  localparam int         BFW    = IW + 2;

  ws_state_t state, state_nx;

  logic           aff_full, aff_empty, aff_pop;
  logic [AFW-1:0] aff_dout;
  logic [IW-1:0]  a_id;
  logic [AW-1:0]  a_addr;
  logic [7:0]     a_len;
  logic [2:0]     a_size;
  logic [1:0]     a_burst;

  logic           wff_full, wff_empty;
  logic [WFW-1:0] wff_dout;
  logic [DW-1:0]  w_data;
  logic [SW-1:0]  w_strb;
  logic           w_last;

  logic           bff_full, bff_empty, b_push;
  logic [1:0]     b_resp;

  logic [IW-1:0]  cur_id;
  logic [AW-1:0]  cur_addr;
  logic [7:0]     cur_len;
  logic [2:0]     cur_size;
  logic [1:0]     cur_burst;
  logic [7:0]     beat_cnt;
  logic           err_q;

  logic           size_err, entry_err, beat_err, beat_fire, last_fire;
  logic [AW-1:0]  incr, aligned, wmask, addr_nx;
  logic [1:0]     eff_burst;

  asi_sfifo #(.DW(AFW), .DEPTH(OD)) u_aff (
    .clk(clk), .rst_n(rst_n),
    .push(AWVALID), .din({AWID, AWADDR, AWLEN, AWSIZE, AWBURST}),
    .pop(aff_pop), .dout(aff_dout), .full(aff_full), .empty(aff_empty)
  );

  asi_sfifo #(.DW(WFW), .DEPTH(WD)) u_wff (
    .clk(clk), .rst_n(rst_n),
    .push(WVALID), .din({WDATA, WSTRB, WLAST}),
    .pop(beat_fire), .dout(wff_dout), .full(wff_full), .empty(wff_empty)
  );

  asi_sfifo #(.DW(BFW), .DEPTH(BD)) u_bff (
    .clk(clk), .rst_n(rst_n),
    .push(b_push), .din({cur_id, b_resp}),
    .pop(BREADY), .dout({BID, BRESP}), .full(bff_full), .empty(bff_empty)
  );

  assign AWREADY = ~aff_full;
  assign WREADY  = ~wff_full;
  assign BVALID  = ~bff_empty;

  assign {a_id, a_addr, a_len, a_size, a_burst} = aff_dout;
  assign {w_data, w_strb, w_last}               = wff_dout;

  // Oversize beats, reserved burst codes and illegal WRAP lengths all end in SLVERR.
  assign entry_err = (a_size > SZ_MAX) || (a_burst == 2'b11) ||
                     ((a_burst == BT_WRAP) && !wrap_len_ok(a_len));
  assign size_err  = (cur_size > SZ_MAX);
  assign m_wlast   = (beat_cnt == cur_len);
  assign beat_fire = (state == WS_BURST) & ~wff_empty & m_wready;
  assign last_fire = beat_fire & m_wlast;
  assign beat_err  = (w_last != m_wlast) | m_werr;
  assign b_resp    = (err_q | (beat_fire & beat_err)) ? RESP_SLVERR : RESP_OKAY;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WS_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      WS_IDLE:  if (!aff_empty) state_nx = WS_BURST;
      WS_BURST: if (last_fire)  state_nx = bff_full ? WS_BRESP : WS_IDLE;
      WS_BRESP: if (!bff_full)  state_nx = WS_IDLE;
      default:                  state_nx = WS_IDLE;
    endcase
  end

  always_comb begin
    aff_pop  = 1'b0;
    m_wvalid = 1'b0;
    b_push   = 1'b0;
    case (state)
      WS_IDLE:  aff_pop = ~aff_empty;
      WS_BURST: begin
        m_wvalid = ~wff_empty;
        b_push   = last_fire & ~bff_full;
      end
      WS_BRESP: b_push = ~bff_full;
      default:  ;
    endcase
  end

  always_comb begin
    incr      = AW'(1) << cur_size;
    aligned   = (cur_addr >> cur_size) << cur_size;
    wmask     = ((AW'(cur_len) + AW'(1)) << cur_size) - AW'(1);
    eff_burst = BT_INCR;
    if (cur_burst == BT_FIXED)                               eff_burst = BT_FIXED;
    else if ((cur_burst == BT_WRAP) && wrap_len_ok(cur_len)) eff_burst = BT_WRAP;
    case (eff_burst)
      BT_FIXED: addr_nx = cur_addr;
      BT_WRAP:  addr_nx = (cur_addr & ~wmask) | ((aligned + incr) & wmask);
      default:  addr_nx = aligned + incr;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_id    <= '0;
      cur_addr  <= '0;
      cur_len   <= '0;
      cur_size  <= '0;
      cur_burst <= '0;
      beat_cnt  <= '0;
      err_q     <= 1'b0;
    end else if (aff_pop) begin
      cur_id    <= a_id;
      cur_addr  <= a_addr;
      cur_len   <= a_len;
      cur_size  <= a_size;
      cur_burst <= a_burst;
      beat_cnt  <= '0;
      err_q     <= entry_err;
    end else if (beat_fire) begin
      cur_addr  <= addr_nx;
      beat_cnt  <= beat_cnt + 8'd1;
      err_q     <= err_q | beat_err;
    end
  end

  assign m_wid    = cur_id;
  assign m_waddr  = cur_addr;
  assign m_wlen   = cur_len;
  assign m_wsize  = cur_size;
  assign m_wburst = cur_burst;
  assign m_wdata  = size_err ? '0 : w_data;
  assign m_wstrb  = size_err ? '0 : w_strb;

endmodule
